ring_inject_queue: RTL

- Core-side injection stage that sits directly upstream of one ring node and drives that node's external packet input (packetSendIn/packetCoreIn) from the core.
- Buffers core packets in a small FIFO and stamps the source ID.
- Holds the head packet stable until the ring accepts it. The ring gives priority to in-flight packets, so injection can be refused for many cycles.
- Tracks occupancy, injected count and starvation.

---
 rtl/ring_inject_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ring_inject_queue.sv
// Core-side injection queue for one ring node: buffers core packets, stamps the
// source ID, and holds the head packet steady until the ring accepts it.

package ring_inject_pkg;
    typedef struct packed {
        logic [7:0]  dest;
        logic [7:0]  src;
        logic [31:0] payload;
    } pkt_t;
endpackage

module ring_inject_queue
    import ring_inject_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                node_id,
    input  logic                      core_valid,
    input  pkt_t                      core_pkt,
    output logic                      core_ready,
    output logic                      net_valid,
    output pkt_t                      net_pkt,
    input  logic                      net_accept,
    output logic [$clog2(DEPTH+2)-1:0] occupancy,
    output logic [CNT_W-1:0]          inj_count,
    output logic                      stall_flag,
    output logic                      drop_self
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + 2);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic {H_EMPTY, H_PRESENT} hold_e;

    hold_e          state, state_nx;
    pkt_t           hold_pkt;
    pkt_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_cnt;
    logic [SW-1:0]  stall_cnt;

    pkt_t stamped;
    logic enq, self_hit, store, accept;
    logic load_fifo, load_core, fifo_push;

    assign core_ready = (fifo_cnt != CW'(DEPTH));
    assign net_valid  = (state == H_PRESENT);
    assign net_pkt    = hold_pkt;

    always_comb begin
        stamped     = core_pkt;
        stamped.src = node_id;
    end

    assign enq      = core_valid && core_ready;
    assign self_hit = enq && (core_pkt.dest == node_id);
    assign store    = enq && !self_hit;
    // Accept is meaningless while nothing is presented.
    assign accept   = (state == H_PRESENT) && net_accept;

    // Holding register refills from the FIFO head first; a fresh packet only
    // falls through when the FIFO has nothing older.
    always_comb begin
        state_nx  = state;
        load_fifo = 1'b0;
        load_core = 1'b0;
        if (state == H_EMPTY || accept) begin
            if (fifo_cnt != '0) begin
                load_fifo = 1'b1;
                state_nx  = H_PRESENT;
            end else if (store) begin
                load_core = 1'b1;
                state_nx  = H_PRESENT;
            end else begin
                state_nx  = H_EMPTY;
            end
        end
        fifo_push = store && !load_core;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= H_EMPTY;
            hold_pkt <= '0;
        end else begin
            state <= state_nx;
            if (load_fifo)
                hold_pkt <= mem[rd_ptr];
            else if (load_core)
                hold_pkt <= stamped;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push)
            mem[wr_ptr] <= stamped;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (load_fifo)
                rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_push, load_fifo})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
            inj_count <= '0;
            drop_self <= 1'b0;
        end else begin
            occupancy <= occupancy + OW'(store) - OW'(accept);
            inj_count <= inj_count + CNT_W'(accept);
            drop_self <= self_hit;
        end
    end

    // Starvation: counter saturates at the limit, flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            stall_flag <= 1'b0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (state == H_PRESENT && stall_cnt != SW'(STALL_LIMIT)) begin
            stall_cnt <= stall_cnt + SW'(1);
            if (stall_cnt == SW'(STALL_LIMIT - 1))
                stall_flag <= 1'b1;
        end
    end

endmodule
